div_seq_n: RTL and testbench
============================

Name: div_seq_n

Overview:
- Parametrised sequential restoring divider. Successor to the team's fixed 8-bit normalising divider.
- Adds a start/ready handshake, a held result with a done flag, synchronous reset, divide-by-zero reporting, and an optional signed mode.
- Normalises the divisor with a leading-one encoder so iteration count tracks divisor magnitude.
- Sits beside the datapath as a multi-cycle arithmetic unit driven by a controller FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk_in  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted on a rising edge when start && ready.
- dividend  in  WIDTH  sampled at accept.
- divisor  in  WIDTH  sampled at accept.
- ready  out  1  high in IDLE and DONE.
- done  out  1  high in DONE; result valid.
- quotient  out  WIDTH  result quotient; held until next accept.
- remainder  out  WIDTH  result remainder; held until next accept.
- dbz  out  1  divide-by-zero flag for the held result.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ready=1; done=0; dbz=0; quotient=0; remainder=0; internal counter=0.
- Reset wins over start. Reset mid-operation aborts; next cycle is IDLE.
- States: IDLE, ITER, FIX (signed build only), DONE.
- Accept (state IDLE or DONE, start=1), unsigned, divisor!=0:
  - p = index of the divisor's leading one; d = WIDTH-1-p.
  - Load normalised divisor (divisor<<d), partial remainder = dividend, quotient reg=0, count=d+1.
  - done drops to 0; state goes to ITER.
- ITER, each cycle:
  - If rem >= ndiv: rem = rem-ndiv and shift 1 into quotient LSB; else shift 0.
  - Then ndiv = ndiv>>1 and count--.
  - When count reaches 0 after an update, go to DONE.
- Latency: accept at edge E0 gives done=1 after edge E0+d+1. For WIDTH=8 the range is 1..8 cycles.
- remainder = final partial remainder. Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
- divisor==0 at accept:
  - Skip ITER; go to DONE after E0+1.
  - dbz=1, quotient = all ones, remainder = dividend.
- dbz is cleared at the next accept.
- DONE: outputs held stable indefinitely. start in DONE is accepted immediately (back-to-back, no IDLE gap).
- start while in ITER: ignored (ready=0); no effect on the running operation.
- Widths: internal compare and subtract at WIDTH bits. The normalised divisor never overflows because d is bounded by the leading-one position.

Optional Feature:
- Macro DIV_SIGNED_EN. When defined, adds input port signed_mode (1 bit, sampled at accept).
- With signed_mode=1:
  - Operands are treated as two's complement and magnitudes are divided.
  - FIX state (one extra cycle) negates quotient if operand signs differ, and negates remainder if dividend is negative. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative (wraps), remainder=0.
  - Divide by zero: dbz=1, quotient = all ones, remainder = dividend (unchanged); no FIX cycle.
- With signed_mode=0, or when the macro is undefined: pure unsigned behaviour as above, FIX never entered, no signed_mode port.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, ITER, FIX, DONE);
  - function for counter width, CNT_W = $clog2(WIDTH+1).
- One natural sub-module: div_penc, a parametrised WIDTH-bit priority encoder returning leading-one index p and a zero flag. The zero flag drives the dbz path.

Test Plan:
- WIDTH=8, reset, then start 100/7 -> d=5, done after 6 cycles, quotient=14, remainder=2, dbz=0.
- 255/1 -> done after 8 cycles, quotient=255, remainder=0. 255/128 -> done after 1 cycle, quotient=1, remainder=127.
- 37/0 -> done after 1 cycle, dbz=1, quotient=0xFF, remainder=37. Next accept 9/3 -> dbz=0, quotient=3, remainder=0.
- Assert rst during ITER of 200/3 -> next cycle ready=1, done=0, quotient=0, remainder=0. A start held during ITER is ignored.
- Back-to-back: start held high in DONE -> new accept the same cycle done is seen. Previous result is stable until that edge.
- DIV_SIGNED_EN, signed_mode=1:
  - -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF).
  - -128/-1 -> quotient=0x80, remainder=0.
  - Random WIDTH=16 sweep checked against the division invariant.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and counter sizing for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_penc.sv
// rtl/div_penc.sv - leading-one priority encoder with all-zero flag
module div_penc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     zero
);

  localparam int IW = $clog2(WIDTH);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/div_seq_n.sv
// rtl/div_seq_n.sv - normalising restoring divider with start/ready handshake; DIV_SIGNED_EN adds signed mode
module div_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);
  import div_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ndiv_q, ndiv_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    lead;
  logic             b_zero;
  logic [CNT_W-1:0] shamt;

`ifdef DIV_SIGNED_EN
  logic fix_q, fix_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic a_neg, b_neg;

  assign a_neg = signed_mode & dividend[WIDTH-1];
  assign b_neg = signed_mode & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  div_penc #(.WIDTH(WIDTH)) u_penc (
    .vec  (b_mag),
    .idx  (lead),
    .zero (b_zero)
  );

  // Shift that puts the divisor's leading one at the MSB; also sets the iteration count.
  assign shamt = CNT_W'(WIDTH - 1) - CNT_W'(lead);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ndiv_d  = ndiv_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    fix_d   = fix_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ITER;
          dbz_d   = b_zero;
          if (b_zero) begin
            quo_d  = '1;
            rem_d  = dividend;
            ndiv_d = '0;
            cnt_d  = CNT_W'(1);
          end else begin
            quo_d  = '0;
            rem_d  = a_mag;
            ndiv_d = b_mag << shamt;
            cnt_d  = shamt + CNT_W'(1);
          end
`ifdef DIV_SIGNED_EN
          fix_d  = signed_mode & ~b_zero;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
`endif
        end
      end
      S_ITER: begin
        // A divide-by-zero result is already loaded; this cycle only paces done.
        if (!dbz_q) begin
          if (rem_q >= ndiv_q) begin
            rem_d = rem_q - ndiv_q;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          ndiv_d = ndiv_q >> 1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
          state_d = fix_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        quo_d   = qneg_q ? -quo_q : quo_q;
        rem_d   = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ndiv_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      fix_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ndiv_q  <= ndiv_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      fix_q   <= fix_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_seq_n.sv
// tb/tb_div_seq_n.sv - scoreboard bench for div_seq_n (WIDTH=8); DIV_SIGNED_EN adds signed cases
module tb_div_seq_n;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, done, dbz;
  logic [W-1:0] quotient, remainder;
`ifdef DIV_SIGNED_EN
  logic         signed_mode = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  div_seq_n #(.WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
`ifdef DIV_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic done_prev = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer division; latency = quotient bit count implied by divisor magnitude.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    exp_t e;
    int   mag, sa, sb;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1;
      return e;
    end
    if (sm) begin
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
      mag = (sb < 0) ? -sb : sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
      mag = int'(b);
    end
    e.z   = 1'b0;
    e.lat = W - $clog2(mag + 1) + 1 + (sm ? 1 : 0);
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: got timeout expected ready");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk_in); #1; n++;
    end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: got timeout expected done");
    end
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_mode = sm;
`endif
    exp_q.push_back(model(a, b, sm));
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    wait_ready();
    start = 1'b1;
    set_op(a, b, sm);
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  // Monitor: pops one expectation per rising done and measures accept-to-done latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            e = exp_q.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("dbz", 32'(dbz), 32'(e.z));
            chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          end
        end
        if (start && ready) acc_cyc = cyc + 1;
        done_prev = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    bit sm;
    int n;

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(posedge clk_in); #1;

    do_div(8'd100, 8'd7, 1'b0);
    wait_done();
    repeat (3) begin
      @(posedge clk_in); #1;
      chk("hold_quotient", 32'(quotient), 32'd14);
      chk("hold_remainder", 32'(remainder), 32'd2);
      chk("hold_done", 32'(done), 32'd1);
    end
    do_div(8'd255, 8'd1, 1'b0);
    do_div(8'd255, 8'd128, 1'b0);
    do_div(8'd37, 8'd0, 1'b0);
    do_div(8'd9, 8'd3, 1'b0);
    wait_done();

    // start during ITER must be ignored
    do_div(8'd200, 8'd3, 1'b0);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    repeat (3) begin
      chk("iter_ready", 32'(ready), 32'd0);
      @(posedge clk_in); #1;
    end
    start = 1'b0;
    wait_done();

    // reset mid-operation, with start asserted through reset
    do_div(8'd200, 8'd3, 1'b0);
    @(posedge clk_in); #1;
    rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(posedge clk_in); #1;
    exp_q.delete();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    @(posedge clk_in); #1;
    chk("rst_over_start", 32'(ready), 32'd1);
    rst = 1'b0; start = 1'b0;
    @(posedge clk_in); #1;

    // back-to-back: start held high, new operands presented when done is seen
    do_div(8'd10, 8'd4, 1'b0);
    wait_done();
    start = 1'b1;
    set_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_in); #1;
      chk("b2b_accept", 32'(done), 32'd0);
      wait_done();
      if (k < 5) set_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 15)), 1'b0);
      else start = 1'b0;
    end

`ifdef DIV_SIGNED_EN
    do_div(8'hF9, 8'd2, 1'b1);
    do_div(8'h80, 8'hFF, 1'b1);
    do_div(8'hF9, 8'd0, 1'b1);
    do_div(8'd7, 8'hFE, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
`ifdef DIV_SIGNED_EN
      sm = bit'($urandom_range(0, 1));
`else
      sm = 1'b0;
`endif
      do_div(a, b, sm);
      if ($urandom_range(0, 3) == 0) wait_done();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk_in); #1; n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk_in); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
